// File: rtl/seq_calc_pkg.sv
// calc_pkg: shared types for the sequential calculator.
//   op_e    - 3-bit operation code carried on the request side of the bus
//   state_e - control state of the calculator (IDLE / EXEC / DONE)
package calc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,  // a + b
        OP_SUBAB = 3'b001,  // a - b
        OP_SUBBA = 3'b010,  // b - a
        OP_ABSA  = 3'b011,  // |a|
        OP_ABSB  = 3'b100,  // |b|
        OP_MUL   = 3'b101,  // a * b, iterative
        OP_ACC   = 3'b110,  // acc + a
        OP_CLR   = 3'b111   // acc = 0
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_calc_if.sv
// seq_calc_if: request/response bus of the sequential calculator.
//   Request : in_valid, in_ready, op, a, b
//   Response: out_valid, out_ready, r, ovf
//   master - the side issuing operations and consuming results
//   slave  - the calculator
interface seq_calc_if #(
    parameter int W = 8
) ();
    import calc_pkg::*;

    logic                in_valid;
    logic                in_ready;
    op_e                 op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] r;
    logic                ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, r, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, r, ovf
    );

endinterface

// File: rtl/seq_calc_addsub_core.sv
// addsub_core: W-bit signed adder/subtractor with two's-complement overflow.
//   a, b : signed operands
//   sub  : 0 -> sum = a + b, 1 -> sum = a - b
//   sum  : low W bits of the result (wraps)
//   ovf  : true result does not fit in W signed bits
module addsub_core #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic [W-1:0] b_eff;

    // Subtraction as a + ~b + 1 so one carry chain serves both directions.
    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {{(W-1){1'b0}}, sub};

    // Overflow: both addends share a sign and the sum's sign differs.
    assign ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/seq_calc.sv
// seq_calc: sequential signed calculator with valid/ready handshakes.
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seq_calc_if slave: op/a/b request, r/ovf response
// Single-cycle ops (add/sub/abs/acc/clr) register their result on the
// accepting edge. Multiply runs radix-2 Booth over W cycles, reusing the
// same adder, and presents the low W product bits.
module seq_calc
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_calc_if.slave bus
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    state_e              state;
    state_e              state_nxt;
    logic                in_ready;
    logic                out_valid;

    logic signed [W-1:0] acc;
    logic signed [W-1:0] r_q;
    logic                ovf_q;

    // Booth multiplier registers: {prod_hi, mplier, booth_q1} shift right
    // each step; mplier ends up holding the low half of the product.
    logic [W-1:0]        mcand;
    logic [W-1:0]        mplier;
    logic [W-1:0]        prod_hi;
    logic                booth_q1;
    logic [CNT_W-1:0]    cnt;

    logic signed [W-1:0] as_a;
    logic signed [W-1:0] as_b;
    logic                as_sub;
    logic signed [W-1:0] as_sum;
    logic                as_ovf;

    logic [W-1:0]        step_hi;
    logic [W-1:0]        step_lo;
    logic                step_sign;

    // ---- control: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- control: next state and handshake outputs ----
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = (bus.op == OP_MUL) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Retire only; a request offered now is taken next cycle in IDLE.
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.r         = r_q;
    assign bus.ovf       = ovf_q;

    // ---- shared adder: operand selection ----
    always_comb begin
        as_a   = '0;
        as_b   = '0;
        as_sub = 1'b0;
        if (state == EXEC) begin
            as_a = prod_hi;
            unique case ({mplier[0], booth_q1})
                2'b01:   as_b = mcand;
                2'b10: begin
                    as_b   = mcand;
                    as_sub = 1'b1;
                end
                default: as_b = '0;
            endcase
        end else begin
            unique case (bus.op)
                OP_ADD: begin
                    as_a = bus.a;
                    as_b = bus.b;
                end
                OP_SUBAB: begin
                    as_a   = bus.a;
                    as_b   = bus.b;
                    as_sub = 1'b1;
                end
                OP_SUBBA: begin
                    as_a   = bus.b;
                    as_b   = bus.a;
                    as_sub = 1'b1;
                end
                OP_ABSA: begin
                    as_b   = bus.a;
                    as_sub = 1'b1;
                end
                OP_ABSB: begin
                    as_b   = bus.b;
                    as_sub = 1'b1;
                end
                OP_ACC: begin
                    as_a = acc;
                    as_b = bus.a;
                end
                default: begin
                    as_a = '0;
                    as_b = '0;
                end
            endcase
        end
    end

    addsub_core #(
        .W(W)
    ) u_addsub (
        .a  (as_a),
        .b  (as_b),
        .sub(as_sub),
        .sum(as_sum),
        .ovf(as_ovf)
    );

    // ---- Booth step: arithmetic shift of the partial product ----
    // The adder result may overflow W bits; the true sign is the wrapped
    // sign flipped by the overflow flag, and after halving it always fits.
    assign step_sign = as_sum[W-1] ^ as_ovf;
    assign step_hi   = {step_sign, as_sum[W-1:1]};
    assign step_lo   = {as_sum[0], mplier[W-1:1]};

    // ---- datapath registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            prod_hi  <= '0;
            booth_q1 <= 1'b0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        unique case (bus.op)
                            OP_MUL: begin
                                mcand    <= bus.a;
                                mplier   <= bus.b;
                                prod_hi  <= '0;
                                booth_q1 <= 1'b0;
                                cnt      <= '0;
                            end
                            OP_ABSA: begin
                                if (bus.a[W-1]) begin
                                    r_q   <= as_sum;
                                    ovf_q <= as_ovf;
                                end else begin
                                    r_q   <= bus.a;
                                    ovf_q <= 1'b0;
                                end
                            end
                            OP_ABSB: begin
                                if (bus.b[W-1]) begin
                                    r_q   <= as_sum;
                                    ovf_q <= as_ovf;
                                end else begin
                                    r_q   <= bus.b;
                                    ovf_q <= 1'b0;
                                end
                            end
                            OP_ACC: begin
                                acc   <= as_sum;
                                r_q   <= as_sum;
                                ovf_q <= as_ovf;
                            end
                            OP_CLR: begin
                                acc   <= '0;
                                r_q   <= '0;
                                ovf_q <= 1'b0;
                            end
                            default: begin
                                r_q   <= as_sum;
                                ovf_q <= as_ovf;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    prod_hi  <= step_hi;
                    mplier   <= step_lo;
                    booth_q1 <= mplier[0];
                    cnt      <= cnt + CNT_W'(1);
                    // Product fits in W bits only if the high half is pure sign extension.
                    if (cnt == LAST_STEP) begin
                        r_q   <= step_lo;
                        ovf_q <= (step_hi != {W{step_lo[W-1]}});
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc.sv
// tb_seq_calc: directed self-checking bench for seq_calc at W=8.
module tb_seq_calc;
    import calc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_calc_if #(.W(8)) bus ();

    seq_calc #(.W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, scramble inputs while busy, wait for the result, retire it.
    task automatic run_op(input string tag, input op_e o, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] er, input logic eo, input int elat);
        int cyc;
        check_val({tag, "_rdy"}, 8'(bus.in_ready), 8'h01);
        bus.op       = o;
        bus.a        = xa;
        bus.b        = xb;
        bus.in_valid = 1'b1;
        step();
        bus.a  = ~xa;
        bus.b  = xb + 8'h35;
        bus.op = OP_ADD;
        cyc    = 1;
        while (!bus.out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_val({tag, "_lat"}, 8'(cyc), 8'(elat));
        check_val({tag, "_r"}, 8'(bus.r), er);
        check_val({tag, "_ovf"}, 8'(bus.ovf), 8'(eo));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val({tag, "_retired"}, 8'(bus.out_valid), 8'h00);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = 8'h00;
        bus.b         = 8'h00;

        repeat (2) step();
        check_val("rst_in_ready", 8'(bus.in_ready), 8'h01);
        check_val("rst_out_valid", 8'(bus.out_valid), 8'h00);
        check_val("rst_r", 8'(bus.r), 8'h00);
        check_val("rst_ovf", 8'(bus.ovf), 8'h00);
        rst_n = 1'b1;
        step();

        // add / subtract boundaries: 100+27=127, 100+28 wraps to -128
        run_op("add_max", OP_ADD, 8'd100, 8'd27, 8'h7F, 1'b0, 1);
        run_op("add_ovf", OP_ADD, 8'd100, 8'd28, 8'h80, 1'b1, 1);
        run_op("subab_ovf", OP_SUBAB, 8'h80, 8'h01, 8'h7F, 1'b1, 1);   // -128-1
        run_op("subba", OP_SUBBA, 8'd3, 8'd10, 8'h07, 1'b0, 1);         // 10-3
        // abs
        run_op("absa_min", OP_ABSA, 8'h80, 8'h11, 8'h80, 1'b1, 1);
        run_op("absb_neg", OP_ABSB, 8'h22, 8'hFB, 8'h05, 1'b0, 1);      // |-5|
        run_op("absa_pos", OP_ABSA, 8'd9, 8'h00, 8'h09, 1'b0, 1);
        // multiply, result 9 cycles after accept
        run_op("mul_m7x9", OP_MUL, 8'hF9, 8'd9, 8'hC1, 1'b0, 9);        // -63
        run_op("mul_16x8", OP_MUL, 8'd16, 8'd8, 8'h80, 1'b1, 9);        // 128
        run_op("mul_minmin", OP_MUL, 8'h80, 8'h80, 8'h00, 1'b1, 9);     // 16384
        run_op("mul_minm1", OP_MUL, 8'h80, 8'hFF, 8'h80, 1'b1, 9);      // 128
        run_op("mul_m1m1", OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b0, 9);       // 1
        // accumulator: 50, 100, 150 wraps to -106
        run_op("acc1", OP_ACC, 8'd50, 8'd7, 8'd50, 1'b0, 1);
        run_op("acc2", OP_ACC, 8'd50, 8'd7, 8'd100, 1'b0, 1);
        run_op("acc3", OP_ACC, 8'd50, 8'd7, 8'h96, 1'b1, 1);
        run_op("clr", OP_CLR, 8'd44, 8'd7, 8'h00, 1'b0, 1);
        run_op("acc_after_clr", OP_ACC, 8'd1, 8'd0, 8'h01, 1'b0, 1);

        // DONE held with consumer stalled and new requests offered
        bus.op       = OP_ADD;
        bus.a        = 8'd1;
        bus.b        = 8'd2;
        bus.in_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.a = 8'(i * 13 + 5);
            bus.b = 8'(i * 7 + 90);
            step();
            check_val("hold_r", 8'(bus.r), 8'h03);
            check_val("hold_ovf", 8'(bus.ovf), 8'h00);
            check_val("hold_out_valid", 8'(bus.out_valid), 8'h01);
            check_val("hold_in_ready", 8'(bus.in_ready), 8'h00);
        end
        // retire and offer in the same cycle: retire only
        bus.a         = 8'd5;
        bus.b         = 8'd5;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("retire_only_ov", 8'(bus.out_valid), 8'h00);
        check_val("retire_only_rdy", 8'(bus.in_ready), 8'h01);
        step();
        bus.in_valid = 1'b0;
        check_val("next_accept_ov", 8'(bus.out_valid), 8'h01);
        check_val("next_accept_r", 8'(bus.r), 8'd10);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // make acc non-zero, then reset in the middle of a multiply
        run_op("acc_pre_rst", OP_ACC, 8'd5, 8'd0, 8'd6, 1'b0, 1);
        bus.op       = OP_MUL;
        bus.a        = 8'd3;
        bus.b        = 8'd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        check_val("midrst_out_valid", 8'(bus.out_valid), 8'h00);
        check_val("midrst_in_ready", 8'(bus.in_ready), 8'h01);
        check_val("midrst_r", 8'(bus.r), 8'h00);
        check_val("midrst_ovf", 8'(bus.ovf), 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check_val("no_stale_result", 8'(seen), 8'h00);
        run_op("acc_post_rst", OP_ACC, 8'd1, 8'd0, 8'h01, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_calc.md
SEQ_CALC -- requirements
Module: seq_calc

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand/result width in bits (W >= 4).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an offered operation this cycle.
REQ-006 The block SHALL have port op, input, 3, meaning the operation code per REQ-011.
REQ-007 The block SHALL have ports a and b, input, W each, meaning signed two's-complement operands.
REQ-008 The block SHALL have port out_valid, output, 1, meaning r/ovf hold a completed result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have ports r (output, W, signed result) and ovf (output, 1, signed overflow flag).

Function
REQ-011 Opcodes SHALL be: 000 a+b; 001 a-b; 010 b-a; 011 abs(a); 100 abs(b); 101 a*b; 110 acc+a; 111 acc clear.
REQ-012 Handshake: an operation SHALL be accepted in any cycle where in_valid and in_ready are both 1; op, a and b are captured at that edge.
REQ-013 States SHALL be IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-014 IDLE: on accept of op 101 go to EXEC; on accept of any other op compute, register r/ovf, go to DONE.
REQ-015 EXEC SHALL perform signed shift-add multiply over exactly W cycles, then go to DONE.
REQ-016 DONE: out_valid = 1; r/ovf held stable; on out_ready = 1 go to IDLE, else remain in DONE.
REQ-017 Latency: non-multiply result valid one cycle after accept; multiply result valid W+1 cycles after accept.
REQ-018 Add/sub ovf SHALL be 1 when the true signed result lies outside [-2^(W-1), 2^(W-1)-1]; r = low W bits (wrap).
REQ-019 abs of -2^(W-1) SHALL give r = -2^(W-1), ovf = 1; all other abs ovf = 0.
REQ-020 Multiply: r = low W bits of the 2W-bit signed product; ovf = 1 when the product does not sign-fit in W bits.
REQ-021 acc SHALL be an internal W-bit register; op 110 sets acc <= acc+a and r = new acc, with ovf per REQ-018 and wrap.
REQ-022 Op 111 SHALL set acc <= 0, r = 0, ovf = 0.
REQ-023 No other op SHALL modify acc.
REQ-024 in_valid while not in IDLE SHALL be ignored; input changes in EXEC SHALL not affect the multiply in progress.
REQ-025 In DONE, out_ready and a new in_valid in the same cycle SHALL retire the result only; the new op is accepted next cycle in IDLE.

Reset
REQ-026 rst_n = 0 SHALL immediately force state IDLE, acc = 0, r = 0, ovf = 0, out_valid = 0, in_ready = 1 without waiting for clk.
REQ-027 Reset asserted during EXEC or DONE SHALL abandon the operation; no result is ever presented for it.
REQ-028 After rst_n deasserts, the first rising edge with in_valid = 1 SHALL accept.

Structure
REQ-029 Shared package calc_pkg SHALL hold the opcode enum (OP_ADD, OP_SUBAB, OP_SUBBA, OP_ABSA, OP_ABSB, OP_MUL, OP_ACC, OP_CLR) and the state enum.
REQ-030 One sub-module addsub_core (parameter W: a, b, sub -> sum, ovf) SHALL serve add, subtract, abs (0 minus operand) and accumulate.
REQ-031 The multiplier SHALL reuse addsub_core or a single W-bit adder; no combinational W x W multiplier.

Verification (W=8)
REQ-032 op 000, a=100, b=27 -> one cycle later out_valid=1, r=-129 wrapped to 127? no: r=0x7F=127, ovf=0; a=100, b=28 -> r=-128, ovf=1.
REQ-033 op 011, a=-128 -> r=-128, ovf=1; op 100, b=-5 -> r=5, ovf=0.
REQ-034 op 101, a=-7, b=9 -> out_valid exactly 9 cycles after accept, r=-63, ovf=0; a=16, b=8 -> r=-128, ovf=1.
REQ-035 op 110 three times with a=50 -> r = 50, 100, -106 (ovf=0, 0, 1); then op 111 -> r=0; then op 110 with a=1 -> r=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> r, ovf, out_valid stable, in_ready=0, no accept.
REQ-037 Assert rst_n=0 mid-EXEC of a multiply -> out_valid=0, in_ready=1, acc=0 immediately; no stale result appears after release.
